// File: rtl/mic_array_pkg.sv
// Shared constants and helpers for the PDM mic-array front end.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: CIC order, warm-up length, PCM clamp limits and midscale,
// accumulator-width derivation and a saturating clamp helper.
package mic_array_pkg;

    localparam int CIC_ORDER     = 4;
    // The first outputs are garbage until every integrator/comb delay has been
    // filled with real data, so this many decimation events are discarded.
    localparam int WARMUP_EVENTS = 4;

    localparam int         PCM_MAX      = 127;
    localparam int         PCM_MIN      = -128;
    localparam logic [7:0] PCM_MIDSCALE = 8'h80;

    // CIC gain is R^N = 2^(N*log2 R). The peak |y| = 2^(N*log2 R) needs one bit
    // beyond that exponent, plus the sign bit.
    function automatic int acc_width(input int decim_log2);
        return 2 + CIC_ORDER * decim_log2;
    endfunction

    function automatic int pcm_hi(input int bw);
        return (1 << (bw - 1)) - 1;
    endfunction

    function automatic int pcm_lo(input int bw);
        return -(1 << (bw - 1));
    endfunction

    // Saturate a signed value into the signed range of a bw-bit PCM word.
    function automatic int sat_pcm(input int v, input int bw);
        if (v > pcm_hi(bw)) begin
            return pcm_hi(bw);
        end else if (v < pcm_lo(bw)) begin
            return pcm_lo(bw);
        end
        return v;
    endfunction

endpackage

// File: rtl/cic_channel.sv
// One PDM channel: 2-flop sync, 4-stage CIC (integrate at bit rate, comb at event rate), scale/clamp/offset.
// Latency: output register loads 5 clk after the decimation event (6 with DC_BLOCK_EN).
// Backpressure: none; strobes come from the shared top-level timing.
//
// Ports: clk/rst_n; pdm_i raw async bit; sample_stb_i bit-rate strobe;
// dec_evt_i capture strobe; comb_stb_i per-comb-stage strobes; dc_stb_i
// (DC_BLOCK_EN builds only) DC filter update; out_stb_i output load;
// pcm_o offset-binary PCM.
// Optional feature macro: DC_BLOCK_EN (one-pole DC-removal high-pass after the clamp).
module cic_channel
    import mic_array_pkg::*;
#(
    parameter int BIT_WIDTH  = 8,
    parameter int DECIM_LOG2 = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 pdm_i,
    input  logic                 sample_stb_i,
    input  logic                 dec_evt_i,
    input  logic [CIC_ORDER-1:0] comb_stb_i,
`ifdef DC_BLOCK_EN
    input  logic                 dc_stb_i,
`endif
    input  logic                 out_stb_i,
    output logic [BIT_WIDTH-1:0] pcm_o
);

    localparam int ACC_W = acc_width(DECIM_LOG2);
    localparam int SHIFT = CIC_ORDER * DECIM_LOG2 - (BIT_WIDTH - 1);
    localparam logic [BIT_WIDTH-1:0] MIDSCALE = {1'b1, {(BIT_WIDTH-1){1'b0}}};

    logic [1:0]              sync_q;
    logic signed [ACC_W-1:0] x_val;
    logic signed [ACC_W-1:0] integ_q    [CIC_ORDER];
    logic signed [ACC_W-1:0] cap_q;
    logic signed [ACC_W-1:0] comb_in    [CIC_ORDER];
    logic signed [ACC_W-1:0] comb_q     [CIC_ORDER];
    logic signed [ACC_W-1:0] comb_dly_q [CIC_ORDER];
    logic signed [ACC_W-1:0] s_full;
    logic signed [BIT_WIDTH-1:0] s_sat;
    logic [BIT_WIDTH-1:0]    pcm_d;
    logic [BIT_WIDTH-1:0]    pcm_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], pdm_i};
        end
    end

    // PDM bit maps to +1 / -1.
    assign x_val = sync_q[1] ? ACC_W'(1) : '1;

    // Each stage consumes the previous stage's registered value, so the
    // cascade is pipelined (one extra sample of delay per stage) and there is
    // no long adder chain. Wrap-around is harmless: the combs undo it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CIC_ORDER; i++) begin
                integ_q[i] <= '0;
            end
        end else if (sample_stb_i) begin
            integ_q[0] <= integ_q[0] + x_val;
            for (int i = 1; i < CIC_ORDER; i++) begin
                integ_q[i] <= integ_q[i] + integ_q[i-1];
            end
        end
    end

    always_comb begin
        comb_in[0] = cap_q;
        for (int k = 1; k < CIC_ORDER; k++) begin
            comb_in[k] = comb_q[k-1];
        end
    end

    // Comb k runs only in the k-th cycle after the event, so its delay
    // register holds the previous event's input (differential delay 1).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_q <= '0;
            for (int k = 0; k < CIC_ORDER; k++) begin
                comb_q[k]     <= '0;
                comb_dly_q[k] <= '0;
            end
        end else begin
            if (dec_evt_i) begin
                cap_q <= integ_q[CIC_ORDER-1];
            end
            for (int k = 0; k < CIC_ORDER; k++) begin
                if (comb_stb_i[k]) begin
                    comb_q[k]     <= comb_in[k] - comb_dly_q[k];
                    comb_dly_q[k] <= comb_in[k];
                end
            end
        end
    end

    // Full scale +2^24 lands on +128 after the shift, hence the clamp.
    assign s_full = comb_q[CIC_ORDER-1] >>> SHIFT;
    assign s_sat  = BIT_WIDTH'(sat_pcm(int'(s_full), BIT_WIDTH));

`ifdef DC_BLOCK_EN
    localparam int YQ_W = BIT_WIDTH + 10;

    logic signed [BIT_WIDTH-1:0] s_prev_q;
    logic signed [YQ_W-1:0]      yq_q;
    logic signed [YQ_W-1:0]      yq_d;
    logic signed [YQ_W-1:0]      s_ext;
    logic signed [YQ_W-1:0]      s_prev_ext;
    logic signed [BIT_WIDTH-1:0] dc_sat;

    // yq carries 8 fractional bits; inputs are pre-shifted by 8 to match.
    assign s_ext      = {{(YQ_W-BIT_WIDTH-8){s_sat[BIT_WIDTH-1]}}, s_sat, 8'h00};
    assign s_prev_ext = {{(YQ_W-BIT_WIDTH-8){s_prev_q[BIT_WIDTH-1]}}, s_prev_q, 8'h00};
    assign yq_d       = s_ext - s_prev_ext + yq_q - (yq_q >>> 8);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_prev_q <= '0;
            yq_q     <= '0;
        end else if (dc_stb_i) begin
            s_prev_q <= s_sat;
            yq_q     <= yq_d;
        end
    end

    assign dc_sat = BIT_WIDTH'(sat_pcm(int'(yq_q >>> 8), BIT_WIDTH));
    assign pcm_d  = {~dc_sat[BIT_WIDTH-1], dc_sat[BIT_WIDTH-2:0]};
`else
    // Adding midscale to a two's-complement word is an MSB flip.
    assign pcm_d = {~s_sat[BIT_WIDTH-1], s_sat[BIT_WIDTH-2:0]};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcm_q <= MIDSCALE;
        end else if (out_stb_i) begin
            pcm_q <= pcm_d;
        end
    end

    assign pcm_o = pcm_q;

endmodule

// File: rtl/pdm_cic_decimator.sv
// PDM mic-array front end: bit-clock divider, shared strobes/warm-up, NUM_MICS CIC channels.
// Latency: pcm_valid 6 clk after the decimation event (7 with DC_BLOCK_EN).
// Backpressure: none; pcm_valid is a one-cycle strobe, data holds until the next one.
//
// Ports: clk, rst_n (async active-low); pdm_clk_out mic bit clock;
// pdm_data_in one async PDM bit per mic; pcm_data_out per-mic offset-binary
// PCM; pcm_valid common update strobe.
// Optional feature macro: DC_BLOCK_EN (per-channel DC-removal high-pass, +1 cycle).
module pdm_cic_decimator
    import mic_array_pkg::*;
#(
    parameter int NUM_MICS   = 9,
    parameter int BIT_WIDTH  = 8,
    parameter int CLK_DIV    = 16,
    parameter int DECIM_LOG2 = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic                 pdm_clk_out,
    input  logic [NUM_MICS-1:0]  pdm_data_in,
    output logic [BIT_WIDTH-1:0] pcm_data_out [0:NUM_MICS-1],
    output logic                 pcm_valid
);

    localparam int CNT_W  = $clog2(CLK_DIV);
    localparam int WARM_W = $clog2(WARMUP_EVENTS + 1);
`ifdef DC_BLOCK_EN
    localparam int LAT = CIC_ORDER + 3;
`else
    localparam int LAT = CIC_ORDER + 2;
`endif

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  pdm_clk_q, pdm_clk_d;
    logic [DECIM_LOG2-1:0] dcnt_q, dcnt_d;
    logic [WARM_W-1:0]     warm_q, warm_d;
    logic [CIC_ORDER-1:0]  evt_sr_q, evt_sr_d;
    logic [LAT-1:0]        vld_sr_q, vld_sr_d;
    logic                  sample_stb;
    logic                  dec_evt;
    logic                  warm_done;

    // The sample strobe is the last high cycle of pdm_clk_out: the mic has
    // had the whole high phase to settle its data through the synchronizer.
    assign sample_stb = (cnt_q == CNT_W'(CLK_DIV - 1));
    assign dec_evt    = sample_stb && (dcnt_q == '1);
    assign warm_done  = (warm_q == WARM_W'(WARMUP_EVENTS));

    always_comb begin
        cnt_d     = sample_stb ? '0 : cnt_q + CNT_W'(1);
        // Derived from cnt_d so the registered clock is high exactly while
        // cnt_q is in the upper half: 50% duty, aligned with the counter.
        pdm_clk_d = (cnt_d >= CNT_W'(CLK_DIV / 2));
        dcnt_d    = sample_stb ? dcnt_q + DECIM_LOG2'(1) : dcnt_q;
        warm_d    = (dec_evt && !warm_done) ? warm_q + WARM_W'(1) : warm_q;
        // evt_sr drives the combs every event (warm-up included) so their
        // delay lines fill; vld_sr only carries events past warm-up.
        evt_sr_d  = {evt_sr_q[CIC_ORDER-2:0], dec_evt};
        vld_sr_d  = {vld_sr_q[LAT-2:0], dec_evt && warm_done};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            pdm_clk_q <= 1'b0;
            dcnt_q    <= '0;
            warm_q    <= '0;
            evt_sr_q  <= '0;
            vld_sr_q  <= '0;
        end else begin
            cnt_q     <= cnt_d;
            pdm_clk_q <= pdm_clk_d;
            dcnt_q    <= dcnt_d;
            warm_q    <= warm_d;
            evt_sr_q  <= evt_sr_d;
            vld_sr_q  <= vld_sr_d;
        end
    end

    assign pdm_clk_out = pdm_clk_q;
    assign pcm_valid   = vld_sr_q[LAT-1];

    for (genvar m = 0; m < NUM_MICS; m++) begin : g_ch
        cic_channel #(
            .BIT_WIDTH  (BIT_WIDTH),
            .DECIM_LOG2 (DECIM_LOG2)
        ) u_ch (
            .clk          (clk),
            .rst_n        (rst_n),
            .pdm_i        (pdm_data_in[m]),
            .sample_stb_i (sample_stb),
            .dec_evt_i    (dec_evt),
            .comb_stb_i   (evt_sr_q),
`ifdef DC_BLOCK_EN
            .dc_stb_i     (vld_sr_q[LAT-3]),
`endif
            .out_stb_i    (vld_sr_q[LAT-2]),
            .pcm_o        (pcm_data_out[m])
        );
    end

endmodule

// File: tb/tb_pdm_cic_decimator.sv
// Self-checking bench for pdm_cic_decimator: per-phase PDM patterns against a
// convolution-based CIC reference (4-fold boxcar kernel), plus divider, strobe
// timing, warm-up and mid-operation reset checks. Honours DC_BLOCK_EN.
module tb_pdm_cic_decimator;

    localparam int NUM_MICS   = 9;
    localparam int BIT_WIDTH  = 8;
    localparam int CLK_DIV    = 16;
    localparam int DECIM_LOG2 = 6;
    localparam int R          = 1 << DECIM_LOG2;
    localparam int FRAME      = R * CLK_DIV;
    localparam int KLEN       = 4 * (R - 1) + 1;
    localparam int SHIFT      = 4 * DECIM_LOG2 - (BIT_WIDTH - 1);
    localparam int MAXS       = 640;
`ifdef DC_BLOCK_EN
    localparam int LAT = 7;
`else
    localparam int LAT = 6;
`endif

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 pdm_clk_out;
    logic [NUM_MICS-1:0]  pdm_data_in;
    logic [BIT_WIDTH-1:0] pcm_data_out [0:NUM_MICS-1];
    logic                 pcm_valid;

    int vectors     = 0;
    int miscompares = 0;

    longint coef [0:KLEN-1];
    bit     xb   [NUM_MICS][MAXS];
    int     mode [NUM_MICS];   // 0 const 0, 1 const 1, 2 alternating, 3 random density
    int     dens [NUM_MICS];
    int     last_exp [NUM_MICS];
    logic signed [17:0] yq_m [NUM_MICS];
    longint sprev_m [NUM_MICS];

    always #5 clk = ~clk;

    pdm_cic_decimator #(
        .NUM_MICS   (NUM_MICS),
        .BIT_WIDTH  (BIT_WIDTH),
        .CLK_DIV    (CLK_DIV),
        .DECIM_LOG2 (DECIM_LOG2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pdm_clk_out  (pdm_clk_out),
        .pdm_data_in  (pdm_data_in),
        .pcm_data_out (pcm_data_out),
        .pcm_valid    (pcm_valid)
    );

    task automatic check_val(input string tag, input logic signed [63:0] got,
                             input logic signed [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Impulse response of (1 + z^-1 + ... + z^-(R-1))^4.
    task automatic build_coef();
        longint tmp [0:KLEN-1];
        for (int i = 0; i < KLEN; i++) coef[i] = 0;
        coef[0] = 1;
        repeat (4) begin
            for (int i = 0; i < KLEN; i++) begin
                tmp[i] = 0;
                for (int j = 0; j < R; j++) begin
                    if (j <= i) tmp[i] += coef[i-j];
                end
            end
            coef = tmp;
        end
    endtask

    task automatic gen_bits();
        for (int m = 0; m < NUM_MICS; m++) begin
            for (int n = 0; n < MAXS; n++) begin
                case (mode[m])
                    0:       xb[m][n] = 1'b0;
                    1:       xb[m][n] = 1'b1;
                    2:       xb[m][n] = (n % 2 == 0);
                    default: xb[m][n] = ($urandom_range(0, 255) < dens[m]);
                endcase
            end
        end
    endtask

    // Clamped scaled CIC output for the event whose last bit is sample n.
    // Four samples of pipeline delay sit ahead of the kernel.
    function automatic longint model_s(input int m, input int n);
        longint y;
        int     idx;
        y = 0;
        for (int j = 0; j < KLEN; j++) begin
            idx = n - 4 - j;
            if (idx >= 0) y += xb[m][idx] ? coef[j] : -coef[j];
        end
        y = y >>> SHIFT;
        if (y > 127) y = 127;
        if (y < -128) y = -128;
        return y;
    endfunction

    task automatic set_all(input int md);
        for (int m = 0; m < NUM_MICS; m++) mode[m] = md;
    endtask

    task automatic run_phase(input string name, input int n_out, input int abort_at);
        int     n_end;
        int     t;
        int     n;
        bit     exp_v;
        longint s;
        longint d;
        int     e;
        gen_bits();
        rst_n = 1'b0;
        for (int m = 0; m < NUM_MICS; m++) begin
            pdm_data_in[m] = xb[m][0];
            last_exp[m]    = 128;
            yq_m[m]        = '0;
            sprev_m[m]     = 0;
        end
        repeat (3) begin
            @(negedge clk);
            check_val({name, "/rst_pdm_clk"}, pdm_clk_out, 0);
            check_val({name, "/rst_valid"}, pcm_valid, 0);
            for (int m = 0; m < NUM_MICS; m++)
                check_val($sformatf("%s/rst_pcm%0d", name, m), pcm_data_out[m], 128);
        end
        rst_n = 1'b1;
        n_end = FRAME * (4 + n_out - 1) + FRAME - 1 + LAT + 2;
        for (int cyc = 0; cyc <= n_end; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (cyc == abort_at) begin
                rst_n = 1'b0;
                #1;
                check_val({name, "/abort_valid"}, pcm_valid, 0);
                check_val({name, "/abort_pdm_clk"}, pdm_clk_out, 0);
                for (int m = 0; m < NUM_MICS; m++)
                    check_val($sformatf("%s/abort_pcm%0d", name, m), pcm_data_out[m], 128);
                return;
            end
            if ((cyc % CLK_DIV == 0) && (cyc / CLK_DIV < MAXS)) begin
                for (int m = 0; m < NUM_MICS; m++) pdm_data_in[m] = xb[m][cyc / CLK_DIV];
            end
            check_val({name, "/pdm_clk"}, pdm_clk_out, ((cyc % CLK_DIV) >= CLK_DIV / 2));
            t     = cyc - (FRAME - 1) - LAT;
            exp_v = (t >= 0) && (t % FRAME == 0) && (t / FRAME >= 4);
            check_val($sformatf("%s/valid@%0d", name, cyc), pcm_valid, exp_v);
            if (exp_v) begin
                n = R * (t / FRAME) + R - 1;
                for (int m = 0; m < NUM_MICS; m++) begin
                    s = model_s(m, n);
`ifdef DC_BLOCK_EN
                    yq_m[m] = 18'((s <<< 8) - (sprev_m[m] <<< 8) + longint'(yq_m[m])
                                  - (longint'(yq_m[m]) >>> 8));
                    sprev_m[m] = s;
                    d = longint'(yq_m[m]) >>> 8;
                    if (d > 127) d = 127;
                    if (d < -128) d = -128;
`else
                    d = s;
`endif
                    e = int'(d) + 128;
                    check_val($sformatf("%s/pcm%0d@%0d", name, m, cyc), pcm_data_out[m], e);
                    last_exp[m] = e;
                end
            end else if (cyc % CLK_DIV == 8) begin
                for (int m = 0; m < NUM_MICS; m++)
                    check_val($sformatf("%s/hold%0d@%0d", name, m, cyc), pcm_data_out[m],
                              last_exp[m]);
            end
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        pdm_data_in = '0;
        build_coef();

        set_all(1);
        run_phase("ones", 3, -1);
        set_all(0);
        run_phase("zeros", 3, -1);
        set_all(2);
        run_phase("alt", 3, -1);

        set_all(2);
        mode[0] = 1;
        mode[1] = 0;
        run_phase("indep", 3, -1);

        set_all(3);
        for (int m = 0; m < NUM_MICS; m++) dens[m] = $urandom_range(0, 256);
        run_phase("rand", 3, -1);

        // Reset lands 3 cycles after the 6th event, inside the comb pipeline.
        for (int m = 0; m < NUM_MICS; m++) dens[m] = $urandom_range(0, 256);
        run_phase("rand_abort", 3, FRAME * 5 + FRAME - 1 + 3);
        for (int m = 0; m < NUM_MICS; m++) dens[m] = $urandom_range(0, 256);
        run_phase("after_abort", 2, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
